factorial_perm_calc: RTL and testbench
======================================

// Module: factorial_perm_calc
// PURPOSE
//  Parametrised successor to the fixed 4-bit/32-bit factorial calculator.
//  Iterative multiply engine: computes n! (MODE=0) or falling factorial nPk = n!/(n-k)! (MODE=1).
//  Reports overflow, sticky until next GO. Widths are generic.
//  Sits behind the control FSM that issues GO and consumes OUTPUT on DONE.
// PARAMETERS
//  N_W    5   width of n and k operands (n max 2^N_W-1)
//  OUT_W  32  width of OUTPUT accumulator
// PORTS
//  clk      in   1      single clock, all logic on rising edge
//  rst      in   1      synchronous, active-high reset
//  GO       in   1      start request, level; sampled only in IDLE
//  MODE     in   1      0 = n!, 1 = nPk; captured with n,k at start
//  n        in   N_W    operand n
//  k        in   N_W    operand k (ignored when MODE=0)
//  DONE     out  1      result valid; held until GO deasserted
//  OUTPUT   out  OUT_W  result; stable while DONE=1
//  OVF      out  1      result exceeded OUT_W bits at some step
//  ERR      out  1      MODE=1 and k>n; OUTPUT=0
//  debugcs  out  4      current state code, zero-extended
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; DONE=0, OUTPUT=0, OVF=0, ERR=0, debugcs=0. Wins over all other inputs,
//   including mid-computation; partial result discarded.
//  States: IDLE=0, LOAD=1, MUL=2, FIN=3.
//  IDLE: GO=1 at edge -> LOAD; capture n,k,MODE; clear OVF, ERR, DONE.
//  LOAD: acc<=1; cnt<=n; steps<=(MODE ? k : n). If MODE=1 and k>n: ERR<=1, acc<=0, steps<=0. -> MUL.
//  MUL: if steps==0 -> FIN; else acc<=acc*cnt (low OUT_W bits), cnt<=cnt-1, steps<=steps-1.
//  FIN: DONE=1, OUTPUT=acc; stays while GO=1; GO=0 at edge -> IDLE, DONE<=0 next cycle.
//  Latency: DONE high m+3 edges after the GO-sampling edge, where m = steps (n or k). n=0 or k=0 -> result 1.
//  Arithmetic: product formed at OUT_W+N_W bits; any nonzero bit above OUT_W-1 sets OVF (sticky for the run).
//  Without SATURATE_EN the accumulator keeps low OUT_W bits (modulo 2^OUT_W).
//  GO inputs in LOAD/MUL are ignored; n/k/MODE changes after capture have no effect.
//  OUTPUT updates only on entry to FIN; holds previous result in IDLE until next LOAD.
// CONFIGURATION
//  SATURATE_EN defined: on first overflow acc forced to {OUT_W{1'b1}} and held for remaining steps; OVF=1.
//  SATURATE_EN undefined: wrap-around modulo 2^OUT_W; OVF still reported.
// STRUCTURE
//  Package factorial_pkg: state encodings (IDLE/LOAD/MUL/FIN), MODE_FACT/MODE_PERM constants, debugcs width.
//  One sub-module: factorial_mul_step, combinational: acc*cnt -> {product[OUT_W-1:0], ovf}; saturation applied here under SATURATE_EN.
//  Top holds FSM, counters, and output registers.
// TESTING (defaults N_W=5, OUT_W=32)
//  MODE=0, n=0..12 sequential with GO pulses -> OUTPUT=n! (12! = 479001600), OVF=0, DONE at n+3 edges.
//  MODE=0, n=13 -> OVF=1; OUTPUT=1932053504 (wrap) or 0xFFFFFFFF (SATURATE_EN).
//  MODE=1, n=10, k=3 -> OUTPUT=720, DONE at 6 edges; n=7, k=0 -> OUTPUT=1.
//  MODE=1, n=3, k=5 -> ERR=1, OUTPUT=0, OVF=0, DONE at 3 edges.
//  rst=1 during MUL of n=10 -> next cycle all outputs 0, debugcs=0; re-run n=5 -> 120.
//  GO held high after DONE -> DONE and OUTPUT stable 20 cycles; n changed meanwhile -> no effect.

Source files
------------

// File: rtl/factorial_pkg.sv
`default_nettype none
// ============================================================================
// Module : factorial_pkg
// Brief  : FSM state encodings, mode constants and debug width for the
//          factorial / falling-factorial engine.
// Rev    : 1.0  initial release
// ============================================================================
package factorial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam logic MODE_FACT = 1'b0;
    localparam logic MODE_PERM = 1'b1;
    localparam int   DBG_W     = 4;

endpackage : factorial_pkg
`default_nettype wire

// File: rtl/factorial_mul_step.sv
`default_nettype none
// ============================================================================
// Module : factorial_mul_step
// Brief  : Combinational acc*cnt step with overflow detection; saturates the
//          product to all ones when SATURATE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module factorial_mul_step #(
    parameter int N_W   = 5,
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0] acc_i,
    input  logic [N_W-1:0]   cnt_i,
    output logic [OUT_W-1:0] product_o,
    output logic             ovf_o
);

    logic [OUT_W+N_W-1:0] full_w;

    assign full_w = {{N_W{1'b0}}, acc_i} * {{OUT_W{1'b0}}, cnt_i};
    assign ovf_o  = |full_w[OUT_W+N_W-1:OUT_W];

`ifdef SATURATE_EN
    // Once saturated, later steps multiply by cnt>=1 and stay saturated.
    assign product_o = ovf_o ? {OUT_W{1'b1}} : full_w[OUT_W-1:0];
`else
    assign product_o = full_w[OUT_W-1:0];
`endif

endmodule : factorial_mul_step
`default_nettype wire

// File: rtl/factorial_perm_calc.sv
`default_nettype none
// ============================================================================
// Module : factorial_perm_calc
// Brief  : Iterative n! (MODE=0) / nPk (MODE=1) engine with sticky overflow.
//          Optional macro SATURATE_EN selects saturating instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module factorial_perm_calc
    import factorial_pkg::*;
#(
    parameter int N_W   = 5,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             GO,
    input  logic             MODE,
    input  logic [N_W-1:0]   n,
    input  logic [N_W-1:0]   k,
    output logic             DONE,
    output logic [OUT_W-1:0] OUTPUT,
    output logic             OVF,
    output logic             ERR,
    output logic [DBG_W-1:0] debugcs
);

    state_e           state_q;
    logic             mode_q;
    logic [N_W-1:0]   n_q;
    logic [N_W-1:0]   k_q;
    logic [OUT_W-1:0] acc_q;
    logic [N_W-1:0]   cnt_q;
    logic [N_W-1:0]   steps_q;
    logic             done_q;
    logic [OUT_W-1:0] out_q;
    logic             ovf_q;
    logic             err_q;

    logic [OUT_W-1:0] acc_d;
    logic             step_ovf_w;

    factorial_mul_step #(
        .N_W   (N_W),
        .OUT_W (OUT_W)
    ) u_mul_step (
        .acc_i     (acc_q),
        .cnt_i     (cnt_q),
        .product_o (acc_d),
        .ovf_o     (step_ovf_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FACT;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (GO) begin
                        mode_q  <= MODE;
                        n_q     <= n;
                        k_q     <= k;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= n_q;
                    state_q <= ST_MUL;
                    if (mode_q == MODE_PERM && k_q > n_q) begin
                        err_q   <= 1'b1;
                        acc_q   <= '0;
                        steps_q <= '0;
                    end else begin
                        acc_q   <= {{(OUT_W-1){1'b0}}, 1'b1};
                        steps_q <= (mode_q == MODE_PERM) ? k_q : n_q;
                    end
                end
                ST_MUL: begin
                    if (steps_q == '0) begin
                        // Result is published only on entry to FIN.
                        done_q  <= 1'b1;
                        out_q   <= acc_q;
                        state_q <= ST_FIN;
                    end else begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_q | step_ovf_w;
                        cnt_q   <= cnt_q - N_W'(1);
                        steps_q <= steps_q - N_W'(1);
                    end
                end
                ST_FIN: begin
                    if (!GO) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DONE    = done_q;
    assign OUTPUT  = out_q;
    assign OVF     = ovf_q;
    assign ERR     = err_q;
    assign debugcs = {{(DBG_W-2){1'b0}}, state_q};

endmodule : factorial_perm_calc
`default_nettype wire

// File: tb/tb_factorial_perm_calc.sv
`default_nettype none
// ============================================================================
// Module : tb_factorial_perm_calc
// Brief  : Directed self-checking bench for factorial_perm_calc.
// Rev    : 1.0  initial release
// ============================================================================
module tb_factorial_perm_calc;

    localparam int N_W   = 5;
    localparam int OUT_W = 32;

    logic             clk;
    logic             rst;
    logic             GO;
    logic             MODE;
    logic [N_W-1:0]   n;
    logic [N_W-1:0]   k;
    logic             DONE;
    logic [OUT_W-1:0] OUTPUT;
    logic             OVF;
    logic             ERR;
    logic [3:0]       debugcs;

    int n_checks;
    int n_fail;

    factorial_perm_calc #(
        .N_W   (N_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .GO      (GO),
        .MODE    (MODE),
        .n       (n),
        .k       (k),
        .DONE    (DONE),
        .OUTPUT  (OUTPUT),
        .OVF     (OVF),
        .ERR     (ERR),
        .debugcs (debugcs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One GO run; returns with DUT in FIN and GO still high.
    task automatic run(input logic mode_v, input int nv, input int kv,
                       input logic [31:0] exp_out, input logic exp_ovf,
                       input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        MODE = mode_v;
        n    = N_W'(nv);
        k    = N_W'(kv);
        GO   = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        check("state_load", 64'(debugcs), 64'd1);
        @(negedge clk);
        n    = N_W'($urandom);
        k    = N_W'($urandom);
        MODE = ~mode_v;
        while (DONE !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("output", 64'(OUTPUT), 64'(exp_out));
        check("ovf", 64'(OVF), 64'(exp_ovf));
        check("err", 64'(ERR), 64'(exp_err));
        check("state_fin", 64'(debugcs), 64'd3);
    endtask

    task automatic release_go(input logic [31:0] exp_out);
        @(negedge clk);
        GO = 1'b0;
        @(posedge clk); #1;
        check("done_drop", 64'(DONE), 64'd0);
        check("state_idle", 64'(debugcs), 64'd0);
        check("output_hold", 64'(OUTPUT), 64'(exp_out));
    endtask

    logic [31:0] fact_tbl [0:12];
    logic [31:0] exp13;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fact_tbl[0]  = 32'd1;
        fact_tbl[1]  = 32'd1;
        fact_tbl[2]  = 32'd2;
        fact_tbl[3]  = 32'd6;
        fact_tbl[4]  = 32'd24;
        fact_tbl[5]  = 32'd120;
        fact_tbl[6]  = 32'd720;
        fact_tbl[7]  = 32'd5040;
        fact_tbl[8]  = 32'd40320;
        fact_tbl[9]  = 32'd362880;
        fact_tbl[10] = 32'd3628800;
        fact_tbl[11] = 32'd39916800;
        fact_tbl[12] = 32'd479001600;
`ifdef SATURATE_EN
        exp13 = 32'hFFFF_FFFF;
`else
        exp13 = 32'd1932053504;
`endif
        rst  = 1'b1;
        GO   = 1'b0;
        MODE = 1'b0;
        n    = '0;
        k    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_output", 64'(OUTPUT), 64'd0);
        check("rst_ovf", 64'(OVF), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        check("rst_state", 64'(debugcs), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 12; i++) begin
            run(1'b0, i, 0, fact_tbl[i], 1'b0, 1'b0, i + 3);
            release_go(fact_tbl[i]);
        end

        run(1'b0, 13, 0, exp13, 1'b1, 1'b0, 16);
        release_go(exp13);

        run(1'b1, 10, 3, 32'd720, 1'b0, 1'b0, 6);
        release_go(32'd720);
        run(1'b1, 7, 0, 32'd1, 1'b0, 1'b0, 3);
        release_go(32'd1);
        run(1'b1, 31, 4, 32'd755160, 1'b0, 1'b0, 7);
        release_go(32'd755160);
        run(1'b1, 3, 5, 32'd0, 1'b0, 1'b1, 3);
        release_go(32'd0);

        // Reset in the middle of a 10! computation.
        @(negedge clk);
        MODE = 1'b0;
        n    = 5'd10;
        GO   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_state_mul", 64'(debugcs), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        GO  = 1'b0;
        @(posedge clk); #1;
        check("mrst_done", 64'(DONE), 64'd0);
        check("mrst_output", 64'(OUTPUT), 64'd0);
        check("mrst_ovf", 64'(OVF), 64'd0);
        check("mrst_err", 64'(ERR), 64'd0);
        check("mrst_state", 64'(debugcs), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // GO held after DONE: result must stay put while inputs wander.
        run(1'b0, 5, 0, 32'd120, 1'b0, 1'b0, 8);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n    = N_W'($urandom);
            k    = N_W'($urandom);
            MODE = 1'($urandom);
            @(posedge clk); #1;
            check("hold_done", 64'(DONE), 64'd1);
            check("hold_output", 64'(OUTPUT), 64'd120);
        end
        release_go(32'd120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_factorial_perm_calc
`default_nettype wire
